// File: rtl/ransac_mem_pkg.sv
// rtl/ransac_mem_pkg.sv - shared widths, priority modes and master index for the RAM arbiter
package ransac_mem_pkg;
    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 32;
    localparam int BE_W_DEF   = DATA_W_DEF / 8;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    typedef enum logic {
        MST_0 = 1'b0,
        MST_1 = 1'b1
    } mst_idx_t;
endpackage

// File: rtl/ransac_rr_arbiter2.sv
// rtl/ransac_rr_arbiter2.sv - two-way single-winner grant with last-grant history and m1 lock
module ransac_rr_arbiter2
    import ransac_mem_pkg::*;
#(
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic req0,
    input  logic req1,
    input  logic lock_req,
    output logic grant0,
    output logic grant1
);
    mst_idx_t last_grant_q, last_grant_d;
    logic     locked_q, locked_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= MST_1;
            locked_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            locked_q     <= locked_d;
        end
    end

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (en) begin
            if (locked_q) begin
                grant1 = req1;
            end else if (req0 && req1) begin
                if (PRIO_MODE == PRIO_FIXED || last_grant_q == MST_1) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    // Lock only arms on an accepted m1 cycle, so a rising m1_lock never steals a cycle m0 already won.
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant1) begin
            last_grant_d = MST_1;
        end else if (grant0) begin
            last_grant_d = MST_0;
        end
        locked_d = lock_req ? (locked_q | grant1) : 1'b0;
    end
endmodule

// File: rtl/ransac_mem_arbiter.sv
// rtl/ransac_mem_arbiter.sv - shares the single-port data RAM between the Nios master and the RANSAC master
module ransac_mem_arbiter
    import ransac_mem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int PRIO_MODE = PRIO_RR,
    localparam int BE_W     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    input  logic              m1_lock,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);
    logic       ready_q, ready_d;
    logic [1:0] rvalid_q, rvalid_d;
    logic       req0, req1, grant0, grant1;
    logic       sel_write;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    ransac_rr_arbiter2 #(
        .PRIO_MODE(PRIO_MODE)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (ready_q),
        .req0    (req0),
        .req1    (req1),
        .lock_req(m1_lock),
        .grant0  (grant0),
        .grant1  (grant1)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q  <= 1'b0;
            rvalid_q <= 2'b00;
        end else begin
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
        end
    end

    // A write wins over a simultaneous read from the same master, so that read never returns data.
    always_comb begin
        ready_d  = 1'b1;
        rvalid_d = {grant1 & m1_read & ~m1_write, grant0 & m0_read & ~m0_write};
    end

    always_comb begin
        m0_waitrequest   = ~ready_q | (req0 & ~grant0);
        m1_waitrequest   = ~ready_q | (req1 & ~grant1);
        sel_write        = grant1 ? m1_write : m0_write;
        mem_chipselect   = grant0 | grant1;
        mem_write        = mem_chipselect & sel_write;
        mem_address      = grant1 ? m1_address : m0_address;
        mem_writedata    = grant1 ? m1_writedata : m0_writedata;
        mem_byteenable   = '1;
        if (mem_write) begin
            mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
        end
        mem_clken        = 1'b1;
        m0_readdata      = mem_readdata;
        m1_readdata      = mem_readdata;
        m0_readdatavalid = rvalid_q[0];
        m1_readdatavalid = rvalid_q[1];
    end
endmodule

// File: tb/tb_ransac_mem_arbiter.sv
// tb/tb_ransac_mem_arbiter.sv - round-robin and fixed-priority arbiters against a cycle model
module tb_ransac_mem_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        m0_read, m0_write, m1_read, m1_write, m1_lock;
    logic [13:0] m0_address, m1_address;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_wd, m1_wd;

    logic        o_w0 [2], o_w1 [2], o_rdv0 [2], o_rdv1 [2], o_cs [2], o_wr [2], o_clken [2];
    logic [13:0] o_addr [2];
    logic [3:0]  o_be [2];
    logic [31:0] o_wd [2], o_rd0 [2], o_rd1 [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic [31:0] ram [16384];
        logic [31:0] rd_q;

        ransac_mem_arbiter #(.ADDR_W(14), .DATA_W(32), .PRIO_MODE(k)) dut (
            .clk(clk), .reset_n(reset_n),
            .m0_address(m0_address), .m0_byteenable(m0_be), .m0_read(m0_read), .m0_write(m0_write),
            .m0_writedata(m0_wd), .m0_waitrequest(o_w0[k]), .m0_readdata(o_rd0[k]),
            .m0_readdatavalid(o_rdv0[k]),
            .m1_address(m1_address), .m1_byteenable(m1_be), .m1_read(m1_read), .m1_write(m1_write),
            .m1_writedata(m1_wd), .m1_waitrequest(o_w1[k]), .m1_readdata(o_rd1[k]),
            .m1_readdatavalid(o_rdv1[k]), .m1_lock(m1_lock),
            .mem_address(o_addr[k]), .mem_byteenable(o_be[k]), .mem_chipselect(o_cs[k]),
            .mem_write(o_wr[k]), .mem_writedata(o_wd[k]), .mem_clken(o_clken[k]),
            .mem_readdata(rd_q)
        );

        initial begin
            for (int i = 0; i < 16384; i++) ram[i] = '0;
            rd_q = '0;
        end

        always @(posedge clk) begin
            if (o_cs[k]) begin
                if (o_wr[k]) begin
                    for (int b = 0; b < 4; b++)
                        if (o_be[k][b]) ram[o_addr[k]][8*b +: 8] <= o_wd[k][8*b +: 8];
                end else begin
                    rd_q <= ram[o_addr[k]];
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model: instance 0 is round-robin, instance 1 is fixed priority.
    bit          m_ready;
    int          m_last [2];
    bit          m_locked [2];
    bit          m_rv [2][2];
    logic [31:0] m_rd [2];
    logic [31:0] mm [int];
    bit          sw0 [2], sw1 [2], sv0 [2], sv1 [2];
    logic [31:0] sd0, sd1;

    typedef struct {
        bit rst; bit r0; bit w0; logic [13:0] a0;
        bit r1; bit w1; logic [13:0] a1; bit lk;
        bit ew0; bit ew1; bit ev0; bit ev1;
    } vec_t;
    vec_t tbl [19];

    function automatic vec_t mk(input int rst, r0, w0, a0, r1, w1, a1, lk, ew0, ew1, ev0, ev1);
        vec_t v;
        v.rst = rst[0]; v.r0 = r0[0]; v.w0 = w0[0]; v.a0 = a0[13:0];
        v.r1 = r1[0]; v.w1 = w1[0]; v.a1 = a1[13:0]; v.lk = lk[0];
        v.ew0 = ew0[0]; v.ew1 = ew1[0]; v.ev0 = ev0[0]; v.ev1 = ev1[0];
        return v;
    endfunction

    function automatic int win(input int k, input bit r0, input bit r1);
        if (!m_ready) return -1;
        if (m_locked[k]) return r1 ? 1 : -1;
        if (r0 && r1) return (k == 1) ? 0 : 1 - m_last[k];
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    function automatic logic [31:0] mem_get(input int a);
        return mm.exists(a) ? mm[a] : 32'h0;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%h required=%h", nm, k, act, exp);
        end
    endtask

    task automatic idle();
        m0_read = 0; m0_write = 0; m0_address = '0; m0_be = 4'hF; m0_wd = '0;
        m1_read = 0; m1_write = 0; m1_address = '0; m1_be = 4'hF; m1_wd = '0;
        m1_lock = 0;
    endtask

    task automatic nxt();
        @(negedge clk);
        idle();
    endtask

    task automatic step();
        bit r0, r1, wr, rd;
        int g;
        logic [13:0] a;
        logic [3:0]  be;
        logic [31:0] wd, v;
        #1;
        if (!reset_n) begin
            m_ready = 0;
            for (int k = 0; k < 2; k++) begin
                m_last[k] = 1; m_locked[k] = 0; m_rv[k][0] = 0; m_rv[k][1] = 0;
            end
        end
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        for (int k = 0; k < 2; k++) begin
            g  = win(k, r0, r1);
            wr = (g == 0) ? m0_write : (g == 1) ? m1_write : 1'b0;
            rd = (g == 0) ? (m0_read & ~m0_write) : (g == 1) ? (m1_read & ~m1_write) : 1'b0;
            a  = (g == 1) ? m1_address : m0_address;
            be = (g == 1) ? m1_be : m0_be;
            wd = (g == 1) ? m1_wd : m0_wd;
            chk("wait0", k, o_w0[k], !m_ready || (r0 && g != 0));
            chk("wait1", k, o_w1[k], !m_ready || (r1 && g != 1));
            chk("rdv0", k, o_rdv0[k], m_rv[k][0]);
            chk("rdv1", k, o_rdv1[k], m_rv[k][1]);
            if (k == 0 && m_rv[0][0]) chk("rdata0", k, o_rd0[k], m_rd[0]);
            if (k == 0 && m_rv[0][1]) chk("rdata1", k, o_rd1[k], m_rd[1]);
            chk("cs", k, o_cs[k], g >= 0);
            chk("mwrite", k, o_wr[k], wr);
            chk("clken", k, o_clken[k], 1);
            if (g >= 0) begin
                chk("maddr", k, o_addr[k], a);
                chk("mbe", k, o_be[k], wr ? be : 4'hF);
                if (wr) chk("mwdata", k, o_wd[k], wd);
            end
            sw0[k] = o_w0[k]; sw1[k] = o_w1[k]; sv0[k] = o_rdv0[k]; sv1[k] = o_rdv1[k];
            if (k == 0) begin
                sd0 = o_rd0[0]; sd1 = o_rd1[0];
                if (wr) begin
                    v = mem_get(int'(a));
                    for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
                    mm[int'(a)] = v;
                end
                if (rd) m_rd[g] = mem_get(int'(a));
            end
            m_rv[k][0] = rd && g == 0;
            m_rv[k][1] = rd && g == 1;
            if (g >= 0) m_last[k] = g;
            m_locked[k] = m1_lock && (m_locked[k] || g == 1);
        end
        m_ready = reset_n;
        @(posedge clk);
    endtask

    initial begin
        idle();
        tbl[0]  = mk(0, 1,0,0,      1,0,0,      0, 1,1,0,0);
        tbl[1]  = mk(0, 1,0,0,      1,0,0,      0, 1,1,0,0);
        tbl[2]  = mk(1, 1,0,0,      1,0,0,      0, 1,1,0,0);
        tbl[3]  = mk(1, 1,0,0,      1,0,0,      0, 0,1,0,0);
        tbl[4]  = mk(1, 0,0,0,      1,0,0,      0, 0,0,1,0);
        tbl[5]  = mk(1, 0,0,0,      0,0,0,      0, 0,0,0,1);
        tbl[6]  = mk(1, 0,1,'h10,   0,1,'h20,   0, 0,1,0,0);
        tbl[7]  = mk(1, 0,1,'h11,   0,1,'h20,   0, 1,0,0,0);
        tbl[8]  = mk(1, 0,1,'h11,   0,1,'h21,   0, 0,1,0,0);
        tbl[9]  = mk(1, 0,1,'h12,   0,1,'h21,   0, 1,0,0,0);
        tbl[10] = mk(1, 0,1,'h12,   0,1,'h22,   0, 0,1,0,0);
        tbl[11] = mk(1, 0,1,'h13,   0,1,'h22,   0, 1,0,0,0);
        tbl[12] = mk(1, 0,0,0,      0,0,0,      0, 0,0,0,0);
        tbl[13] = mk(1, 0,1,'h300,  1,0,'h200,  1, 0,1,0,0);
        tbl[14] = mk(1, 0,1,'h301,  1,0,'h200,  1, 1,0,0,0);
        tbl[15] = mk(1, 0,1,'h301,  0,0,'h200,  1, 1,0,0,1);
        tbl[16] = mk(1, 0,1,'h301,  0,1,'h200,  0, 1,0,0,0);
        tbl[17] = mk(1, 0,1,'h301,  0,0,0,      0, 0,0,0,0);
        tbl[18] = mk(1, 0,0,0,      0,0,0,      0, 0,0,0,0);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            reset_n    = tbl[i].rst;
            m0_read    = tbl[i].r0; m0_write = tbl[i].w0; m0_address = tbl[i].a0;
            m0_be      = 4'hF;      m0_wd    = 32'hA000_0000 | {18'h0, tbl[i].a0};
            m1_read    = tbl[i].r1; m1_write = tbl[i].w1; m1_address = tbl[i].a1;
            m1_be      = 4'hF;      m1_wd    = 32'hB000_0000 | {18'h0, tbl[i].a1};
            m1_lock    = tbl[i].lk;
            step();
            chk("tbl_wait0", i, sw0[0], tbl[i].ew0);
            chk("tbl_wait1", i, sw1[0], tbl[i].ew1);
            chk("tbl_rdv0", i, sv0[0], tbl[i].ev0);
            chk("tbl_rdv1", i, sv1[0], tbl[i].ev1);
        end

        for (int i = 0; i < 4; i++) begin
            nxt();
            m0_write = 1; m0_address = 14'h400 + 14'(i); m0_wd = $urandom;
            m1_write = 1; m1_address = 14'h500 + 14'(i); m1_wd = $urandom;
            step();
            chk("fx_m0_wins", i, sw0[1], 0);
            chk("fx_m1_waits", i, sw1[1], 1);
        end
        nxt();
        m1_write = 1; m1_address = 14'h504; m1_wd = 32'h5555_0504;
        step();
        chk("fx_m1_granted", 0, sw1[1], 0);

        nxt(); m0_write = 1; m0_address = 14'h100; m0_wd = 32'h1122_3344; step();
        nxt(); m0_write = 1; m0_address = 14'h100; m0_wd = 32'hAABB_CCDD; m0_be = 4'b0011; step();
        nxt(); m0_read = 1; m0_address = 14'h100; step();
        chk("be_accept", 0, sw0[0], 0);
        chk("be_rdv_early", 0, sv0[0], 0);
        nxt(); step();
        chk("be_rdv", 0, sv0[0], 1);
        chk("be_data", 0, sd0, 32'h1122_CCDD);

        for (int i = 0; i < 6; i++) begin
            logic [13:0] a;
            a = (i < 3) ? 14'h10 + 14'(i) : 14'h20 + 14'(i - 3);
            nxt(); m0_read = 1; m0_address = a; step();
            nxt(); step();
            chk("rr_readback", i, sd0, (i < 3) ? (32'hA000_0000 | {18'h0, a}) : (32'hB000_0000 | {18'h0, a}));
        end

        nxt(); m1_read = 1; m1_address = 14'h200; step();
        chk("mr_accept", 0, sw1[0], 0);
        nxt(); reset_n = 0; m0_read = 1; step();
        chk("mr_rdv_reset", 0, sv1[0], 0);
        chk("mr_wait_reset", 0, sw0[0], 1);
        nxt(); reset_n = 1; step();
        chk("mr_rdv_after", 0, sv1[0], 0);
        nxt(); step();

        for (int i = 0; i < 400; i++) begin
            nxt();
            m0_read = 1'($urandom_range(0, 1)); m0_write = 1'($urandom_range(0, 1));
            m0_address = 14'($urandom_range(0, 15)); m0_be = 4'($urandom); m0_wd = $urandom;
            m1_read = 1'($urandom_range(0, 1)); m1_write = 1'($urandom_range(0, 1));
            m1_address = 14'($urandom_range(0, 15)); m1_be = 4'($urandom); m1_wd = $urandom;
            m1_lock = ($urandom_range(0, 3) == 0);
            step();
        end
        nxt(); step();
        nxt(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
